raw_from_32: RTL and testbench

- Inverse of the raw 32-bit packer: takes the 32-bit word stream (plain 2x16 or 10-bit packed 8+2) and restores one raw pixel per 16-bit output word with dtype tags.
- Sits on the host-to-imager replay path, feeding pixel-domain blocks that expect the native 16-bit raw stream.
- Has a ready output toward upstream because one input word expands to up to 16 output cycles.

---
 rtl/raw_from_32_pkg.sv | 26 ++
 rtl/raw_from_32_group_buf.sv | 81 ++++++++
 rtl/raw_from_32.sv | 225 ++++++++++++++++++++++
 tb/tb_raw_from_32.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/raw_from_32_pkg.sv
// Shared dtype encoding and local constants for the raw 32-bit unpacker.
// Pixel dtypes are all codes whose bits under DTYPE_PIXEL_MASK equal DTYPE_PIXEL's.
package raw_from_32_pkg;

    localparam int unsigned DTYPE_WIDTH = 4;

    localparam logic [DTYPE_WIDTH-1:0] DTYPE_PIXEL      = 4'h0;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_PIXEL_MASK = 4'hC;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_HEADER     = 4'h8;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_ROW_END    = 4'h9;

    localparam int unsigned GROUP_WORDS  = 5;
    localparam int unsigned GROUP_PIXELS = 16;

    typedef enum logic [1:0] {
        StIdle,
        StSplit,
        StDrain,
        StRowEnd
    } state_e;

    function automatic logic is_pixel_dtype(input logic [DTYPE_WIDTH-1:0] dtype);
        return (dtype & DTYPE_PIXEL_MASK) == (DTYPE_PIXEL & DTYPE_PIXEL_MASK);
    endfunction

endpackage

// File: rtl/raw_from_32_group_buf.sv
// Five-word buffer for one packed group (4 MSB words + 1 LSB word) and the
// combinational extractor that rebuilds pixel k of a run of len pixels.
// Ports:
//   clk_i, reset_i          clock, async active-high reset
//   wr_en_i, wr_data_i      append one word at position count
//   clear_i                 empty the buffer (wins over a write)
//   count_o                 number of buffered words (0..5)
//   last_word_o             most recently buffered word (0 when empty)
//   k_i, len_i              pixel index and run length for the extractor
//   lsb_word_i              word carrying the 2-bit LSBs of the run
//   pixel_o                 {zero pad, msb8, lsb2}
module raw_from_32_group_buf
    import raw_from_32_pkg::*;
#(
    parameter int unsigned PIXEL_WIDTH = 10
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        wr_en_i,
    input  logic [31:0] wr_data_i,
    input  logic        clear_i,
    output logic [2:0]  count_o,
    output logic [31:0] last_word_o,
    input  logic [3:0]  k_i,
    input  logic [4:0]  len_i,
    input  logic [31:0] lsb_word_i,
    output logic [15:0] pixel_o
);

    localparam int unsigned PadBits = 16 - PIXEL_WIDTH;

    logic [31:0] words_q [GROUP_WORDS];
    logic [2:0]  count_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= '0;
            for (int i = 0; i < GROUP_WORDS; i++) begin
                words_q[i] <= '0;
            end
        end else if (clear_i) begin
            count_q <= '0;
        end else if (wr_en_i && (count_q < 3'(GROUP_WORDS))) begin
            for (int i = 0; i < GROUP_WORDS; i++) begin
                if (3'(i) == count_q) begin
                    words_q[i] <= wr_data_i;
                end
            end
            count_q <= count_q + 3'd1;
        end
    end

    assign count_o = count_q;

    always_comb begin
        last_word_o = '0;
        for (int i = 0; i < GROUP_WORDS; i++) begin
            if (3'(i + 1) == count_q) begin
                last_word_o = words_q[i];
            end
        end
    end

    logic [31:0] msb_word;
    logic [4:0]  msb_shift;
    logic [7:0]  msb8;
    logic [3:0]  lsb_idx;
    logic [1:0]  lsb2;

    // Pixel 4j+b sits in byte (3-b) of MSB word j; LSB pairs are right-aligned,
    // so pixel k's pair is at position len-1-k counted from bit 0.
    always_comb begin
        msb_word  = words_q[k_i[3:2]];
        msb_shift = {~k_i[1:0], 3'b000};
        msb8      = 8'(msb_word >> msb_shift);
        lsb_idx   = 4'(len_i - 5'd1 - {1'b0, k_i});
        lsb2      = 2'(lsb_word_i >> {lsb_idx, 1'b0});
        pixel_o   = 16'({{PadBits{1'b0}}, msb8, lsb2});
    end

endmodule

// File: rtl/raw_from_32.sv
// Raw 32-bit word stream to 16-bit pixel stream unpacker.
// pack=0: pixel and header words split into low then high 16-bit halves.
// pack=1: 10-bit 8+2 groups are buffered and drained one pixel per cycle;
//         ROW_END drains the partial group using the last word as trailer.
// Optional macro RAW_FROM_32_CHECK_EN enables the sticky err flag.
// Ports:
//   clk, reset       clock, async active-high reset
//   datai, dvi       input word and valid (taken when dvi && readyo)
//   dtypei           input dtype
//   pack             1 = packed 8+2 format; stable within a frame
//   readyo           high only while idle
//   datao, dvo       output word and valid (no backpressure)
//   dtypeo           output dtype
//   err              sticky protocol error (tied 0 without the macro)
module raw_from_32
    import raw_from_32_pkg::*;
#(
    parameter int unsigned PIXEL_WIDTH = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            datai,
    input  logic                   dvi,
    input  logic [DTYPE_WIDTH-1:0] dtypei,
    input  logic                   pack,
    output logic                   readyo,
    output logic [15:0]            datao,
    output logic                   dvo,
    output logic [DTYPE_WIDTH-1:0] dtypeo,
    output logic                   err
);

    state_e                 state_q, state_d;
    logic [3:0]             k_q, k_d;
    logic [4:0]             len_q, len_d;
    logic                   rowend_q, rowend_d;
    logic [15:0]            hi_q, hi_d;
    logic [DTYPE_WIDTH-1:0] hi_dtype_q, hi_dtype_d;
    logic                   dvo_q, dvo_d;
    logic [15:0]            datao_q, datao_d;
    logic [DTYPE_WIDTH-1:0] dtypeo_q, dtypeo_d;

    logic        buf_wr, buf_clr;
    logic [2:0]  buf_count;
    logic [31:0] buf_last;
    logic [3:0]  ext_k;
    logic [4:0]  ext_len;
    logic [31:0] ext_lsb;
    logic [15:0] ext_pixel;
    logic        proto_err;

    logic in_pixel, in_header, in_row_end;
    assign in_pixel   = is_pixel_dtype(dtypei);
    assign in_header  = (dtypei == DTYPE_HEADER);
    assign in_row_end = (dtypei == DTYPE_ROW_END);

    raw_from_32_group_buf #(
        .PIXEL_WIDTH(PIXEL_WIDTH)
    ) u_group_buf (
        .clk_i      (clk),
        .reset_i    (reset),
        .wr_en_i    (buf_wr),
        .wr_data_i  (datai),
        .clear_i    (buf_clr),
        .count_o    (buf_count),
        .last_word_o(buf_last),
        .k_i        (ext_k),
        .len_i      (ext_len),
        .lsb_word_i (ext_lsb),
        .pixel_o    (ext_pixel)
    );

    // Extractor operands. Pixel 0 is produced on the accept cycle, where the
    // 5th word is still on datai rather than in the buffer.
    always_comb begin
        if (state_q == StDrain) begin
            ext_k   = k_q;
            ext_len = len_q;
            ext_lsb = buf_last;
        end else if (pack && in_pixel) begin
            ext_k   = '0;
            ext_len = 5'(GROUP_PIXELS);
            ext_lsb = datai;
        end else begin
            ext_k   = '0;
            ext_len = {buf_count - 3'd1, 2'b00};
            ext_lsb = buf_last;
        end
    end

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        len_d      = len_q;
        rowend_d   = rowend_q;
        hi_d       = hi_q;
        hi_dtype_d = hi_dtype_q;
        dvo_d      = 1'b0;
        datao_d    = '0;
        dtypeo_d   = '0;
        buf_wr     = 1'b0;
        buf_clr    = 1'b0;
        proto_err  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (dvi) begin
                    if (pack && in_pixel) begin
                        proto_err = (dtypei != DTYPE_PIXEL);
                        buf_wr    = 1'b1;
                        if (buf_count == 3'(GROUP_WORDS - 1)) begin
                            dvo_d    = 1'b1;
                            datao_d  = ext_pixel;
                            dtypeo_d = DTYPE_PIXEL;
                            k_d      = 4'd1;
                            len_d    = 5'(GROUP_PIXELS);
                            rowend_d = 1'b0;
                            state_d  = StDrain;
                        end
                    end else if (pack && in_row_end) begin
                        if (buf_count > 3'd1) begin
                            // Partial group: last word is the trailer.
                            dvo_d    = 1'b1;
                            datao_d  = ext_pixel;
                            dtypeo_d = DTYPE_PIXEL;
                            k_d      = 4'd1;
                            len_d    = ext_len;
                            rowend_d = 1'b1;
                            state_d  = StDrain;
                        end else begin
                            proto_err = (buf_count == 3'd0);
                            buf_clr   = 1'b1;
                            dvo_d     = 1'b1;
                            dtypeo_d  = DTYPE_ROW_END;
                        end
                    end else begin
                        // Any other word aborts a partial group.
                        if (pack && (buf_count != 3'd0)) begin
                            buf_clr   = 1'b1;
                            proto_err = 1'b1;
                        end
                        dvo_d    = 1'b1;
                        datao_d  = datai[15:0];
                        dtypeo_d = dtypei;
                        if ((!pack && in_pixel) || in_header) begin
                            hi_d       = datai[31:16];
                            hi_dtype_d = dtypei;
                            state_d    = StSplit;
                        end
                    end
                end
            end
            StSplit: begin
                dvo_d    = 1'b1;
                datao_d  = hi_q;
                dtypeo_d = hi_dtype_q;
                state_d  = StIdle;
            end
            StDrain: begin
                dvo_d    = 1'b1;
                datao_d  = ext_pixel;
                dtypeo_d = DTYPE_PIXEL;
                k_d      = k_q + 4'd1;
                if ({1'b0, k_q} == (len_q - 5'd1)) begin
                    buf_clr = 1'b1;
                    state_d = rowend_q ? StRowEnd : StIdle;
                end
            end
            StRowEnd: begin
                dvo_d    = 1'b1;
                dtypeo_d = DTYPE_ROW_END;
                state_d  = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            k_q        <= '0;
            len_q      <= '0;
            rowend_q   <= 1'b0;
            hi_q       <= '0;
            hi_dtype_q <= '0;
            dvo_q      <= 1'b0;
            datao_q    <= '0;
            dtypeo_q   <= '0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            len_q      <= len_d;
            rowend_q   <= rowend_d;
            hi_q       <= hi_d;
            hi_dtype_q <= hi_dtype_d;
            dvo_q      <= dvo_d;
            datao_q    <= datao_d;
            dtypeo_q   <= dtypeo_d;
        end
    end

    assign readyo = (state_q == StIdle);
    assign dvo    = dvo_q;
    assign datao  = datao_q;
    assign dtypeo = dtypeo_q;

`ifdef RAW_FROM_32_CHECK_EN
    logic err_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (proto_err) begin
            err_q <= 1'b1;
        end
    end
    assign err = err_q;
`else
    logic unused_proto_err;
    assign unused_proto_err = proto_err;
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_raw_from_32.sv
module tb_raw_from_32;
    import raw_from_32_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] datai;
    logic        dvi;
    logic [3:0]  dtypei;
    logic        pack;
    logic        readyo;
    logic [15:0] datao;
    logic        dvo;
    logic [3:0]  dtypeo;
    logic        err;

    raw_from_32 #(
        .PIXEL_WIDTH(10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .datai (datai),
        .dvi   (dvi),
        .dtypei(dtypei),
        .pack  (pack),
        .readyo(readyo),
        .datao (datao),
        .dvo   (dvo),
        .dtypeo(dtypeo),
        .err   (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [19:0] got_q[$];
    logic [19:0] exp_q[$];
    int          got_cyc[$];
    logic [31:0] mbuf[$];
    logic        model_err;
    logic        exp_err;
    int          n_cmp;
    int          n_fail;
    int          last_acc;

    always @(negedge clk) begin
        if (!reset && dvo) begin
            got_q.push_back({dtypeo, datao});
            got_cyc.push_back(cyc);
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    // Reference pixel: msb byte (k%4 from the top) of its MSB word, LSB pair
    // counted from the right end of the trailer/LSB word.
    function automatic logic [15:0] mpix(input logic [31:0] msbw, input logic [31:0] lsbw,
                                         input int k, input int p);
        int b;
        int l;
        b = int'((msbw >> (24 - 8 * (k % 4))) & 32'hFF);
        l = int'((lsbw >> (2 * (p - 1 - k))) & 32'h3);
        return 16'(b * 4 + l);
    endfunction

    task automatic model_word(input logic [31:0] d, input logic [3:0] t);
        bit pix;
        int m;
        pix = ((t & DTYPE_PIXEL_MASK) == DTYPE_PIXEL);
        if (pack && pix) begin
            if (t != DTYPE_PIXEL) model_err = 1'b1;
            mbuf.push_back(d);
            if (mbuf.size() == 5) begin
                for (int k = 0; k < 16; k++)
                    exp_q.push_back({DTYPE_PIXEL, mpix(mbuf[k / 4], mbuf[4], k, 16)});
                mbuf.delete();
            end
        end else if (pack && t == DTYPE_ROW_END) begin
            m = mbuf.size();
            if (m == 0) model_err = 1'b1;
            for (int k = 0; k < 4 * (m - 1); k++)
                exp_q.push_back({DTYPE_PIXEL, mpix(mbuf[k / 4], mbuf[m - 1], k, 4 * (m - 1))});
            exp_q.push_back({DTYPE_ROW_END, 16'h0000});
            mbuf.delete();
        end else begin
            if (pack && mbuf.size() > 0) begin
                model_err = 1'b1;
                mbuf.delete();
            end
            exp_q.push_back({t, d[15:0]});
            if ((!pack && pix) || t == DTYPE_HEADER) exp_q.push_back({t, d[31:16]});
        end
    endtask

    task automatic send(input logic [31:0] d, input logic [3:0] t);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!readyo && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!readyo) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_ready_timeout got readyo=%0b required 1", readyo);
        end
        datai  = d;
        dtypei = t;
        dvi    = 1'b1;
        @(posedge clk);
        #1;
        last_acc = cyc;
        dvi      = 1'b0;
        model_word(d, t);
    endtask

    task automatic wait_drain(output bit timed_out);
        int g;
        g = 0;
        while ((got_q.size() < exp_q.size() || !readyo) && g < 300) begin
            @(negedge clk);
            g++;
        end
        timed_out = (g >= 300);
        repeat (4) @(negedge clk);
    endtask

    task automatic flush_queues();
        got_q.delete();
        got_cyc.delete();
        exp_q.delete();
    endtask

    function automatic logic [3:0] expected_err_value();
`ifdef RAW_FROM_32_CHECK_EN
        return {3'b000, model_err};
`else
        return 4'h0;
`endif
    endfunction

    task automatic test_reset();
        reset  = 1'b1;
        dvi    = 1'b0;
        pack   = 1'b0;
        datai  = '0;
        dtypei = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (dvo !== 1'b0) begin n_fail++; $display("FAIL rst_dvo got=%b req=0", dvo); end
        n_cmp++; if (datao !== 16'h0) begin n_fail++; $display("FAIL rst_datao got=%h req=0", datao); end
        n_cmp++; if (dtypeo !== 4'h0) begin n_fail++; $display("FAIL rst_dtypeo got=%h req=0", dtypeo); end
        n_cmp++; if (readyo !== 1'b1) begin n_fail++; $display("FAIL rst_readyo got=%b req=1", readyo); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err got=%b req=0", err); end
        @(negedge clk);
        reset     = 1'b0;
        model_err = 1'b0;
        flush_queues();
    endtask

    task automatic test_unpacked();
        bit to;
        int acc;
        logic [3:0] ch [6];
        ch = '{4'h0, 4'h1, 4'h8, 4'h9, 4'hA, 4'h5};
        pack = 1'b0;
        send(32'h0234_0123, DTYPE_PIXEL);
        acc = last_acc;
        @(negedge clk);
        n_cmp++; if (readyo !== 1'b0) begin n_fail++; $display("FAIL unpk_busy got=%b req=0", readyo); end
        @(negedge clk);
        n_cmp++; if (readyo !== 1'b1) begin n_fail++; $display("FAIL unpk_ready got=%b req=1", readyo); end
        wait_drain(to);
        n_cmp++;
        if (to || got_q.size() != 2) begin
            n_fail++; $display("FAIL unpk_count got=%0d req=2", got_q.size());
        end else begin
            n_cmp++; if (got_q[0] !== {DTYPE_PIXEL, 16'h0123}) begin
                n_fail++; $display("FAIL unpk_lo got=%h req=%h", got_q[0], {DTYPE_PIXEL, 16'h0123});
            end
            n_cmp++; if (got_q[1] !== {DTYPE_PIXEL, 16'h0234}) begin
                n_fail++; $display("FAIL unpk_hi got=%h req=%h", got_q[1], {DTYPE_PIXEL, 16'h0234});
            end
            n_cmp++; if (got_cyc[0] != acc || got_cyc[1] != acc + 1) begin
                n_fail++; $display("FAIL unpk_timing got=%0d,%0d req=%0d,%0d",
                                   got_cyc[0], got_cyc[1], acc, acc + 1);
            end
        end
        flush_queues();
        for (int i = 0; i < 24; i++) send($urandom, ch[$urandom_range(0, 5)]);
        wait_drain(to);
        n_cmp++;
        if (to || got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL unpk_rand_count got=%0d req=%0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_cmp++;
                if (got_q[i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL unpk_rand[%0d] got=%h req=%h", i, got_q[i], exp_q[i]);
                end
            end
        end
        flush_queues();
    endtask

    task automatic test_packed_group();
        bit to;
        int acc;
        pack = 1'b1;
        send(32'h8040_2010, DTYPE_PIXEL);
        send(32'h0804_0201, DTYPE_PIXEL);
        send(32'hFF00_0000, DTYPE_PIXEL);
        send(32'h0000_0000, DTYPE_PIXEL);
        send(32'hC000_0003, DTYPE_PIXEL);
        acc = last_acc;
        wait_drain(to);
        n_cmp++;
        if (to || got_q.size() != 16) begin
            n_fail++; $display("FAIL grp_count got=%0d req=16", got_q.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                n_cmp++;
                if (got_q[i] !== exp_q[i] || got_cyc[i] != acc + i) begin
                    n_fail++; $display("FAIL grp_pix[%0d] got=%h@%0d req=%h@%0d",
                                       i, got_q[i], got_cyc[i], exp_q[i], acc + i);
                end
            end
            n_cmp++; if (got_q[0][15:0] !== 16'h0203) begin
                n_fail++; $display("FAIL grp_p0 got=%h req=0203", got_q[0][15:0]); end
            n_cmp++; if (got_q[1][15:0] !== 16'h0100) begin
                n_fail++; $display("FAIL grp_p1 got=%h req=0100", got_q[1][15:0]); end
            n_cmp++; if (got_q[8][15:0] !== 16'h03FC) begin
                n_fail++; $display("FAIL grp_p8 got=%h req=03fc", got_q[8][15:0]); end
            n_cmp++; if (got_q[15][15:0] !== 16'h0003) begin
                n_fail++; $display("FAIL grp_p15 got=%h req=0003", got_q[15][15:0]); end
        end
        flush_queues();
    endtask

    task automatic test_row_end();
        bit to;
        int acc;
        pack = 1'b1;
        send(32'h1122_3344, DTYPE_PIXEL);
        send(32'h0000_00E4, DTYPE_PIXEL);
        send(32'h0000_0000, DTYPE_ROW_END);
        acc = last_acc;
        wait_drain(to);
        n_cmp++;
        if (to || got_q.size() != 5) begin
            n_fail++; $display("FAIL rowend_count got=%0d req=5", got_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_cmp++;
                if (got_q[i] !== exp_q[i] || got_cyc[i] != acc + i) begin
                    n_fail++; $display("FAIL rowend_out[%0d] got=%h@%0d req=%h@%0d",
                                       i, got_q[i], got_cyc[i], exp_q[i], acc + i);
                end
            end
        end
        flush_queues();
    endtask

    task automatic test_full_then_trailer();
        bit to;
        int acc;
        pack = 1'b1;
        for (int i = 0; i < 5; i++) send($urandom, DTYPE_PIXEL);
        send(32'h0000_0000, DTYPE_PIXEL);
        send(32'h0000_0000, DTYPE_ROW_END);
        acc = last_acc;
        wait_drain(to);
        n_cmp++;
        if (to || got_q.size() != 17) begin
            n_fail++; $display("FAIL full_count got=%0d req=17", got_q.size());
        end else begin
            for (int i = 0; i < 17; i++) begin
                n_cmp++;
                if (got_q[i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL full_out[%0d] got=%h req=%h", i, got_q[i], exp_q[i]);
                end
            end
            n_cmp++;
            if (got_cyc[16] != acc) begin
                n_fail++; $display("FAIL full_rowend_cycle got=%0d req=%0d", got_cyc[16], acc);
            end
        end
        flush_queues();
    endtask

    task automatic test_header_err();
        bit to;
        pack = 1'b1;
        send(32'hDEAD_BEEF, DTYPE_HEADER);
        send(32'h0000_0000, DTYPE_ROW_END);
        wait_drain(to);
        n_cmp++;
        if (to || got_q.size() != 3) begin
            n_fail++; $display("FAIL hdr_count got=%0d req=3", got_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (got_q[i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL hdr_out[%0d] got=%h req=%h", i, got_q[i], exp_q[i]);
                end
            end
        end
        exp_err = expected_err_value()[0];
        n_cmp++; if (err !== exp_err) begin
            n_fail++; $display("FAIL hdr_err got=%b req=%b", err, exp_err); end
        flush_queues();
    endtask

    task automatic test_random_packed();
        bit to;
        int ng;
        int nm;
        pack = 1'b1;
        for (int r = 0; r < 12; r++) begin
            ng = $urandom_range(0, 2);
            for (int g = 0; g < 5 * ng; g++) send($urandom, DTYPE_PIXEL);
            nm = $urandom_range(0, 3);
            for (int j = 0; j < nm; j++)
                send($urandom, ($urandom_range(0, 9) == 0) ? 4'h1 : DTYPE_PIXEL);
            if ($urandom_range(0, 9) == 0) send($urandom, 4'hA);
            if ($urandom_range(0, 4) != 0) send($urandom, DTYPE_PIXEL);
            send($urandom, DTYPE_ROW_END);
        end
        wait_drain(to);
        n_cmp++;
        if (to || got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL rpk_count got=%0d req=%0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_cmp++;
                if (got_q[i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL rpk_out[%0d] got=%h req=%h", i, got_q[i], exp_q[i]);
                end
            end
        end
        exp_err = expected_err_value()[0];
        n_cmp++; if (err !== exp_err) begin
            n_fail++; $display("FAIL rpk_err got=%b req=%b", err, exp_err); end
        flush_queues();
    endtask

    task automatic test_reset_mid_drain();
        bit to;
        pack = 1'b1;
        for (int i = 0; i < 5; i++) send($urandom, DTYPE_PIXEL);
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (dvo !== 1'b1) begin n_fail++; $display("FAIL mid_dvo got=%b req=1", dvo); end
        #1;
        reset = 1'b1;
        #1;
        n_cmp++; if (dvo !== 1'b0) begin n_fail++; $display("FAIL mid_rst_dvo got=%b req=0", dvo); end
        n_cmp++; if (readyo !== 1'b1) begin
            n_fail++; $display("FAIL mid_rst_ready got=%b req=1", readyo); end
        @(negedge clk);
        reset     = 1'b0;
        model_err = 1'b0;
        mbuf.delete();
        flush_queues();
        for (int i = 0; i < 5; i++) send($urandom, DTYPE_PIXEL);
        wait_drain(to);
        n_cmp++;
        if (to || got_q.size() != 16) begin
            n_fail++; $display("FAIL mid_after_count got=%0d req=16", got_q.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                n_cmp++;
                if (got_q[i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL mid_after[%0d] got=%h req=%h", i, got_q[i], exp_q[i]);
                end
            end
        end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL mid_err got=%b req=0", err); end
        flush_queues();
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        model_err = 1'b0;
        test_reset();
        test_unpacked();
        test_packed_group();
        test_row_end();
        test_full_then_trailer();
        test_header_err();
        test_random_packed();
        test_reset_mid_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
